mem_access_sequencer: RTL and testbench

- Parametrised multi-cycle memory-stage controller for the LC-3b/LC-3X pipeline.
- Replaces single-cycle load/store control with a sequenced engine: direct loads/stores, indirect (LDI/STI) two-phase accesses, byte stores and variable-latency memory responses.
- Drives the data-memory port and holds the pipeline via stall until each access completes.
- Sits between the MEM-stage control word and the data cache.

---
 rtl/mem_access_sequencer_if.sv | 47 ++++
 rtl/mem_access_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request, data-memory and completion signals of the MEM-stage access sequencer.
// The sequencer takes the slave side; the pipeline/cache model takes the master side.
interface mem_access_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    localparam int BE_W = WIDTH / 8;

    // MEM-stage request
    logic             start;
    logic             op_write;
    logic             indirect;
    logic             byte_op;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [BE_W-1:0]  byte_sel;
    logic             flush;

    // Data-memory port
    logic             mem_resp;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic [BE_W-1:0]  mem_byte_enable;

    // Pipeline status and completion
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] rdata_out;
    logic [CNT_W-1:0] wait_cycles;

    modport slave (
        input  start, op_write, indirect, byte_op, addr, wdata, byte_sel, flush,
        input  mem_resp, mem_rdata,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output stall, done, rdata_out, wait_cycles
    );

    modport master (
        output start, op_write, indirect, byte_op, addr, wdata, byte_sel, flush,
        output mem_resp, mem_rdata,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  stall, done, rdata_out, wait_cycles
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multi-cycle MEM-stage controller: direct and indirect (pointer-first) loads and
// stores, byte stores, variable-latency memory. Holds the pipeline with stall
// until the access completes and reports the number of memory wait cycles.
module mem_access_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_sequencer_if.slave  bus
);
    localparam int BE_W  = WIDTH / 8;
    localparam int LSB_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_write;
    logic             r_byte;
    logic [WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]  r_bsel;
    logic             r_kill;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [WIDTH-1:0] r_mem_address;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [BE_W-1:0]  r_mem_be;
    logic             r_done;
    logic [WIDTH-1:0] r_rdata;
    logic [CNT_W-1:0] r_wait;

    logic             w_accept;
    logic             w_kill;
    logic [CNT_W-1:0] w_cnt_next;

    // Word accesses go out on a naturally aligned address.
    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:LSB_W], {LSB_W{1'b0}}};
    endfunction

    // Byte accesses keep the full address so the cache can pick the lane.
    function automatic logic [WIDTH-1:0] data_addr(input logic [WIDTH-1:0] a,
                                                   input logic             is_byte);
        return is_byte ? a : align(a);
    endfunction

    // Only byte stores narrow the enables; byte loads read the whole word.
    function automatic logic [BE_W-1:0] data_be(input logic            is_write,
                                                input logic            is_byte,
                                                input logic [BE_W-1:0] sel);
        return (is_write && is_byte) ? sel : {BE_W{1'b1}};
    endfunction

    assign w_accept   = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_kill     = r_kill || bus.flush;
    assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Sequencer state, latched request, memory port and completion registers.
    // NOTE: every register here uses <= so all reads see the pre-edge values;
    // mixing in blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_write       <= 1'b0;
            r_byte        <= 1'b0;
            r_wdata       <= '0;
            r_bsel        <= '0;
            r_kill        <= 1'b0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_done        <= 1'b0;
            r_rdata       <= '0;
            r_wait        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_kill <= 1'b0;
                    if (w_accept) begin
                        r_write <= bus.op_write;
                        r_byte  <= bus.byte_op;
                        r_wdata <= bus.wdata;
                        r_bsel  <= bus.byte_sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (bus.indirect) begin
                            r_state       <= PTR;
                            r_mem_read    <= 1'b1;
                            r_mem_write   <= 1'b0;
                            r_mem_address <= align(bus.addr);
                            r_mem_be      <= {BE_W{1'b1}};
                            r_mem_wdata   <= '0;
                        end else begin
                            r_state       <= DATA;
                            r_mem_read    <= !bus.op_write;
                            r_mem_write   <= bus.op_write;
                            r_mem_address <= data_addr(bus.addr, bus.byte_op);
                            r_mem_be      <= data_be(bus.op_write, bus.byte_op, bus.byte_sel);
                            r_mem_wdata   <= bus.op_write ? bus.wdata : '0;
                        end
                    end
                end

                PTR: begin
                    if (!bus.mem_resp) begin
                        r_cnt <= w_cnt_next;
                        if (bus.flush) r_kill <= 1'b1;
                    end else if (w_kill) begin
                        // Killed: the pointer read has finished, so drop out quietly.
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_mem_read <= 1'b0;
                    end else begin
                        // The fetched pointer becomes the data-phase address directly.
                        r_state       <= DATA;
                        r_mem_read    <= !r_write;
                        r_mem_write   <= r_write;
                        r_mem_address <= data_addr(bus.mem_rdata, r_byte);
                        r_mem_be      <= data_be(r_write, r_byte, r_bsel);
                        r_mem_wdata   <= r_write ? r_wdata : '0;
                    end
                end

                DATA: begin
                    if (!bus.mem_resp) begin
                        r_cnt <= w_cnt_next;
                        if (bus.flush) r_kill <= 1'b1;
                    end else begin
                        r_busy      <= 1'b0;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (w_kill) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_wait  <= r_cnt;
                            if (!r_write) r_rdata <= bus.mem_rdata;
                        end
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall is registered while an access is in flight, plus the accept term so
    // the stage presenting the request is held in the same cycle.
    assign bus.stall           = r_busy || w_accept;
    assign bus.mem_read        = r_mem_read;
    assign bus.mem_write       = r_mem_write;
    assign bus.mem_address     = r_mem_address;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_byte_enable = r_mem_be;
    assign bus.done            = r_done;
    assign bus.rdata_out       = r_rdata;
    assign bus.wait_cycles     = r_wait;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed table, hand-written corner sequences
// and random transactions scored against a timeline model of the access rules.
module tb_mem_access_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_sequencer_if #(.WIDTH(16), .CNT_W(8)) bus16 ();
    mem_access_sequencer_if #(.WIDTH(32), .CNT_W(3)) bus32 ();

    mem_access_sequencer #(.WIDTH(16), .CNT_W(8)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    mem_access_sequencer #(.WIDTH(32), .CNT_W(3)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    typedef struct {
        bit          op_write;
        bit          indirect;
        bit          byte_op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  byte_sel;
        int          ptr_lat;
        int          data_lat;
        logic [15:0] ptr_rdata;
        logic [15:0] data_rdata;
        int          flush_at;   // cycle index relative to start; -1 = never
    } vec_t;

    typedef struct {
        bit          start_stall;
        int          n_acc;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [1:0]  be_last;
        bit          wr_last;
        logic [15:0] wdata_last;
        int          done_cnt;
        int          done_cyc;
        logic [15:0] rdata;
        logic [7:0]  wait_c;
        int          stall_bad;
        int          excl_bad;
    } res_t;

    typedef struct {
        vec_t v;
        res_t e;
    } row_t;

    int checks   = 0;
    int failures = 0;
    logic [15:0] prev_rd;
    logic [7:0]  prev_wt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_vec(bit w, bit ind, bit b, logic [15:0] a, logic [15:0] wd,
                                    logic [1:0] sel, int pl, int dl, logic [15:0] prd,
                                    logic [15:0] drd, int fl);
        vec_t v;
        v.op_write = w;  v.indirect = ind; v.byte_op = b;
        v.addr = a;      v.wdata = wd;     v.byte_sel = sel;
        v.ptr_lat = pl;  v.data_lat = dl;
        v.ptr_rdata = prd; v.data_rdata = drd; v.flush_at = fl;
        return v;
    endfunction

    function automatic res_t mk_res(bit ss, int n, logic [15:0] a0, logic [15:0] a1,
                                    logic [1:0] be, bit wr, logic [15:0] wd, int dc, int dcy,
                                    logic [15:0] rd, logic [7:0] wt);
        res_t e;
        e.start_stall = ss; e.n_acc = n; e.addr0 = a0; e.addr1 = a1;
        e.be_last = be; e.wr_last = wr; e.wdata_last = wd;
        e.done_cnt = dc; e.done_cyc = dcy; e.rdata = rd; e.wait_c = wt;
        e.stall_bad = 0; e.excl_bad = 0;
        return e;
    endfunction

    // Timeline model: accept at cycle 0, each memory phase lasts latency+1 cycles,
    // completion one cycle after the last response unless a flush hit a busy cycle.
    function automatic res_t model(vec_t v, logic [15:0] prd, logic [7:0] pwt);
        res_t        e;
        int          pe;
        int          de;
        int          lat_sum;
        bit          kill;
        bit          kill_ptr;
        logic [15:0] da;
        e = mk_res(0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0, 0, prd, pwt);
        if (v.flush_at == 0) return e;
        e.start_stall = 1;
        pe = v.indirect ? 1 + v.ptr_lat : 0;
        de = (v.indirect ? pe + 1 : 1) + v.data_lat;
        kill = (v.flush_at >= 1) && (v.flush_at <= de);
        kill_ptr = v.indirect && kill && (v.flush_at <= pe);
        da = v.indirect ? v.ptr_rdata : v.addr;
        if (!v.byte_op) da[0] = 1'b0;
        if (v.indirect) begin
            e.addr0 = {v.addr[15:1], 1'b0};
            e.addr1 = da;
            e.n_acc = kill_ptr ? 1 : 2;
        end else begin
            e.addr0 = da;
            e.n_acc = 1;
        end
        if (kill_ptr) begin
            e.be_last = 2'b11;
            e.wr_last = 0;
        end else begin
            e.be_last    = (v.op_write && v.byte_op) ? v.byte_sel : 2'b11;
            e.wr_last    = v.op_write;
            e.wdata_last = v.wdata;
        end
        if (!kill) begin
            e.done_cnt = 1;
            e.done_cyc = de + 1;
            if (!v.op_write) e.rdata = v.data_rdata;
            lat_sum = (v.indirect ? v.ptr_lat : 0) + v.data_lat;
            e.wait_c = (lat_sum > 255) ? 8'd255 : 8'(lat_sum);
        end
        return e;
    endfunction

    // Presents one request to the 16-bit instance and plays the memory for a
    // bounded window, recording what appears on the port.
    task automatic run_txn(input vec_t v, output res_t o);
        int   window;
        int   acc_cyc;
        int   lat;
        logic strobe;
        logic resp;
        logic prev_strobe;
        logic prev_resp;
        o = mk_res(0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, 0, 0, 16'h0, 8'h0);
        window = v.ptr_lat + v.data_lat + 8;
        @(posedge clk); #1;
        bus16.start    = 1'b1;
        bus16.op_write = v.op_write;
        bus16.indirect = v.indirect;
        bus16.byte_op  = v.byte_op;
        bus16.addr     = v.addr;
        bus16.wdata    = v.wdata;
        bus16.byte_sel = v.byte_sel;
        bus16.flush    = (v.flush_at == 0);
        bus16.mem_resp = 1'b0;
        #1;
        o.start_stall = bus16.stall;
        prev_strobe = 1'b0;
        prev_resp   = 1'b0;
        acc_cyc     = 0;
        for (int c = 1; c <= window; c++) begin
            @(posedge clk); #1;
            bus16.start    = 1'b0;
            bus16.op_write = 1'($urandom);
            bus16.indirect = 1'($urandom);
            bus16.byte_op  = 1'($urandom);
            bus16.addr     = 16'($urandom);
            bus16.wdata    = 16'($urandom);
            bus16.byte_sel = 2'($urandom);
            bus16.flush    = (c == v.flush_at);
            strobe = bus16.mem_read || bus16.mem_write;
            if (bus16.mem_read && bus16.mem_write) o.excl_bad++;
            resp = 1'b0;
            if (strobe) begin
                if (!prev_strobe || prev_resp) begin
                    o.n_acc++;
                    acc_cyc = 0;
                    if (o.n_acc == 1) o.addr0 = bus16.mem_address;
                    else              o.addr1 = bus16.mem_address;
                end
                o.be_last    = bus16.mem_byte_enable;
                o.wr_last    = bus16.mem_write;
                o.wdata_last = bus16.mem_wdata;
                lat = (v.indirect && o.n_acc == 1) ? v.ptr_lat : v.data_lat;
                if (acc_cyc == lat) resp = 1'b1;
                acc_cyc++;
            end
            bus16.mem_resp  = resp;
            bus16.mem_rdata = resp ? ((v.indirect && o.n_acc == 1) ? v.ptr_rdata : v.data_rdata)
                                   : 16'($urandom);
            #1;
            if (strobe && !bus16.stall) o.stall_bad++;
            if (bus16.done) begin
                o.done_cnt++;
                o.done_cyc = c;
                if (bus16.stall) o.stall_bad++;
            end
            prev_strobe = strobe;
            prev_resp   = resp;
        end
        bus16.flush    = 1'b0;
        bus16.mem_resp = 1'b0;
        o.rdata  = bus16.rdata_out;
        o.wait_c = bus16.wait_cycles;
    endtask

    task automatic compare(input string tag, input res_t o, input res_t e);
        check($sformatf("%s_start_stall", tag), 32'(o.start_stall), 32'(e.start_stall));
        check($sformatf("%s_n_acc", tag), o.n_acc, e.n_acc);
        if (e.n_acc >= 1) begin
            check($sformatf("%s_addr0", tag), 32'(o.addr0), 32'(e.addr0));
            check($sformatf("%s_be", tag), 32'(o.be_last), 32'(e.be_last));
            check($sformatf("%s_write", tag), 32'(o.wr_last), 32'(e.wr_last));
            if (e.wr_last) check($sformatf("%s_wdata", tag), 32'(o.wdata_last), 32'(e.wdata_last));
        end
        if (e.n_acc == 2) check($sformatf("%s_addr1", tag), 32'(o.addr1), 32'(e.addr1));
        check($sformatf("%s_done_cnt", tag), o.done_cnt, e.done_cnt);
        if (e.done_cnt == 1) check($sformatf("%s_done_cyc", tag), o.done_cyc, e.done_cyc);
        check($sformatf("%s_rdata", tag), 32'(o.rdata), 32'(e.rdata));
        check($sformatf("%s_wait", tag), 32'(o.wait_c), 32'(e.wait_c));
        check($sformatf("%s_stall_hold", tag), o.stall_bad, 0);
        check($sformatf("%s_strobe_excl", tag), o.excl_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        row_t        tbl[10];
        res_t        o;
        res_t        e;
        vec_t        v;
        int          pe;
        int          de;
        logic [31:0] a32;
        logic [3:0]  be32;
        int          acc32;
        int          done32_cyc;
        logic        resp32;

        tbl[0].v = mk_vec(0, 0, 0, 16'h1235, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'hBEEF, -1);
        tbl[0].e = mk_res(1, 1, 16'h1234, 16'h0000, 2'b11, 0, 16'h0000, 1, 2, 16'hBEEF, 8'd0);
        tbl[1].v = mk_vec(0, 1, 0, 16'h0040, 16'h0000, 2'b00, 3, 2, 16'h3000, 16'h00AA, -1);
        tbl[1].e = mk_res(1, 2, 16'h0040, 16'h3000, 2'b11, 0, 16'h0000, 1, 8, 16'h00AA, 8'd5);
        tbl[2].v = mk_vec(1, 0, 1, 16'h2001, 16'h5A5A, 2'b10, 0, 1, 16'h0000, 16'h1111, -1);
        tbl[2].e = mk_res(1, 1, 16'h2001, 16'h0000, 2'b10, 1, 16'h5A5A, 1, 3, 16'h00AA, 8'd1);
        tbl[3].v = mk_vec(0, 1, 0, 16'h0100, 16'h0000, 2'b00, 3, 1, 16'h5000, 16'h7777, 2);
        tbl[3].e = mk_res(1, 1, 16'h0100, 16'h0000, 2'b11, 0, 16'h0000, 0, 0, 16'h00AA, 8'd1);
        tbl[4].v = mk_vec(1, 0, 0, 16'h4003, 16'hC0DE, 2'b01, 0, 2, 16'h0000, 16'h2222, -1);
        tbl[4].e = mk_res(1, 1, 16'h4002, 16'h0000, 2'b11, 1, 16'hC0DE, 1, 4, 16'h00AA, 8'd2);
        tbl[5].v = mk_vec(0, 0, 1, 16'h0777, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0077, -1);
        tbl[5].e = mk_res(1, 1, 16'h0777, 16'h0000, 2'b11, 0, 16'h0000, 1, 2, 16'h0077, 8'd0);
        tbl[6].v = mk_vec(1, 1, 0, 16'h0201, 16'h1234, 2'b01, 1, 3, 16'h0601, 16'h3333, 5);
        tbl[6].e = mk_res(1, 2, 16'h0200, 16'h0600, 2'b11, 1, 16'h1234, 0, 0, 16'h0077, 8'd0);
        tbl[7].v = mk_vec(0, 0, 0, 16'h0AAA, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'hFFFF, 0);
        tbl[7].e = mk_res(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0077, 8'd0);
        tbl[8].v = mk_vec(0, 0, 0, 16'h0010, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h1357, 2);
        tbl[8].e = mk_res(1, 1, 16'h0010, 16'h0000, 2'b11, 0, 16'h0000, 1, 2, 16'h1357, 8'd0);
        tbl[9].v = mk_vec(0, 0, 0, 16'h0020, 16'h0000, 2'b00, 0, 1, 16'h0000, 16'h9999, 2);
        tbl[9].e = mk_res(1, 1, 16'h0020, 16'h0000, 2'b11, 0, 16'h0000, 0, 0, 16'h1357, 8'd0);

        reset = 1'b1;
        bus16.start = 1'b0; bus16.op_write = 1'b0; bus16.indirect = 1'b0; bus16.byte_op = 1'b0;
        bus16.addr = '0; bus16.wdata = '0; bus16.byte_sel = '0; bus16.flush = 1'b0;
        bus16.mem_resp = 1'b0; bus16.mem_rdata = '0;
        bus32.start = 1'b0; bus32.op_write = 1'b0; bus32.indirect = 1'b0; bus32.byte_op = 1'b0;
        bus32.addr = '0; bus32.wdata = '0; bus32.byte_sel = '0; bus32.flush = 1'b0;
        bus32.mem_resp = 1'b0; bus32.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_mem_read", 32'(bus16.mem_read), 0);
        check("reset_mem_write", 32'(bus16.mem_write), 0);
        check("reset_stall", 32'(bus16.stall), 0);
        check("reset_done", 32'(bus16.done), 0);
        check("reset_address", 32'(bus16.mem_address), 0);
        check("reset_be", 32'(bus16.mem_byte_enable), 0);
        check("reset_rdata", 32'(bus16.rdata_out), 0);
        check("reset_wait", 32'(bus16.wait_cycles), 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].v, o);
            compare($sformatf("tbl%0d", i), o, tbl[i].e);
        end
        prev_rd = tbl[9].e.rdata;
        prev_wt = tbl[9].e.wait_c;

        // Reset while DATA waits for mem_resp
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.op_write = 1'b0; bus16.indirect = 1'b0; bus16.byte_op = 1'b0;
        bus16.addr = 16'h0900; bus16.flush = 1'b0; bus16.mem_resp = 1'b0;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_pre_read", 32'(bus16.mem_read), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_mid_read", 32'(bus16.mem_read), 0);
        check("rst_mid_write", 32'(bus16.mem_write), 0);
        check("rst_mid_stall", 32'(bus16.stall), 0);
        check("rst_mid_done", 32'(bus16.done), 0);
        check("rst_mid_rdata", 32'(bus16.rdata_out), 0);
        check("rst_mid_wait", 32'(bus16.wait_cycles), 0);
        prev_rd = '0;
        prev_wt = '0;
        v = mk_vec(0, 0, 0, 16'h0902, 16'h0000, 2'b00, 0, 1, 16'h0000, 16'h4321, -1);
        e = model(v, prev_rd, prev_wt);
        run_txn(v, o);
        compare("after_reset", o, e);
        prev_rd = e.rdata;
        prev_wt = e.wait_c;

        // Randomised transactions against the model
        for (int i = 0; i < 40; i++) begin
            v = mk_vec(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                       2'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       16'($urandom), 16'($urandom), -1);
            pe = v.indirect ? 1 + v.ptr_lat : 0;
            de = (v.indirect ? pe + 1 : 1) + v.data_lat;
            if ($urandom_range(0, 3) == 0) v.flush_at = int'($urandom_range(0, de + 1));
            e = model(v, prev_rd, prev_wt);
            run_txn(v, o);
            compare($sformatf("rnd%0d", i), o, e);
            prev_rd = e.rdata;
            prev_wt = e.wait_c;
        end

        // A start presented during DONE must not be accepted; done is one cycle wide
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.op_write = 1'b0; bus16.indirect = 1'b0; bus16.byte_op = 1'b0;
        bus16.addr = 16'h0ABC; bus16.flush = 1'b0;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        check("dstart_read", 32'(bus16.mem_read), 1);
        bus16.mem_resp = 1'b1; bus16.mem_rdata = 16'h2468;
        @(posedge clk); #1;
        bus16.mem_resp = 1'b0;
        bus16.start = 1'b1; bus16.addr = 16'h0DEF;
        #1;
        check("dstart_done", 32'(bus16.done), 1);
        check("dstart_stall", 32'(bus16.stall), 0);
        @(posedge clk); #1;
        bus16.start = 1'b0;
        #1;
        check("dstart_no_read", 32'(bus16.mem_read), 0);
        check("dstart_done_clear", 32'(bus16.done), 0);
        check("dstart_rdata", 32'(bus16.rdata_out), 32'h2468);

        // 32-bit instance with a 3-bit counter: alignment and saturation
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.addr = 32'h0000_1003;
        a32 = '0; be32 = '0; acc32 = 0; done32_cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            bus32.start = 1'b0;
            resp32 = 1'b0;
            if (bus32.mem_read) begin
                if (acc32 == 0) begin
                    a32  = bus32.mem_address;
                    be32 = bus32.mem_byte_enable;
                end
                if (acc32 == 12) resp32 = 1'b1;
                acc32++;
            end
            bus32.mem_resp  = resp32;
            bus32.mem_rdata = resp32 ? 32'hDEAD_BEEF : $urandom;
            #1;
            if (bus32.done) done32_cyc = c;
        end
        bus32.mem_resp = 1'b0;
        check("w32_addr", a32, 32'h0000_1000);
        check("w32_be", 32'(be32), 32'hF);
        check("w32_done_cyc", done32_cyc, 14);
        check("w32_wait_sat", 32'(bus32.wait_cycles), 7);
        check("w32_rdata", bus32.rdata_out, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
